dmem_bridge_rv32: RTL and testbench

- Data-side memory bridge directly downstream of the core's memory-access port.
- Converts the core's single-cycle request strobe (memory-request, read/write, address, data) into a valid/ready bus transaction toward the DCache/SRAM.
- Drives the core's data-stall input until the transaction completes.
- Returns registered read data and flags bus errors and misalignment.

---
 rtl/rv32_mem_pkg.sv | 40 ++++
 rtl/bus_wdog_rv32.sv | 38 +++
 rtl/dmem_bridge_rv32.sv | 131 +++++++++++++
 tb/tb_dmem_bridge_rv32.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// ============================================================================
// Module  : rv32_mem_pkg
// Brief   : Shared types, byte-enable constants and the alignment check for
//           the RV32 data-memory bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memState_t;

  // Only naturally aligned byte, halfword and word lane sets are legal;
  // an empty enable set is treated as misaligned as well.
  function automatic logic isMisaligned(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF_LO, BE_HALF_HI, BE_WORD: isMisaligned = 1'b0;
      default:                          isMisaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_wdog_rv32.sv
// ============================================================================
// Module  : bus_wdog_rv32
// Brief   : Bus request watchdog; oExpired flags the last allowed wait cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_wdog_rv32 #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClr,
  input  logic iEn,
  output logic oExpired
);

  localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt <= '0;
    end else if (iClr) begin
      r_cnt <= '0;
    end else if (iEn) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Counter holds the waits already seen, so this cycle is wait number LIMIT.
  assign oExpired = (r_cnt == c_lastCnt);

endmodule

`default_nettype wire

// File: rtl/dmem_bridge_rv32.sv
// ============================================================================
// Module  : dmem_bridge_rv32
// Brief   : Core memory strobe to valid/ready bus bridge with stall and error
//           reporting. Optional bus timeout under macro BUS_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_bridge_rv32
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMEM,
  input  logic              iRW,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iWDATA,
  input  logic [3:0]        iBE,
  output logic [DATA_W-1:0] oRDATA,
  output logic              oStallD,
  output logic              oERR,
  output logic              oBUS_VALID,
  output logic              oBUS_WE,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [DATA_W-1:0] oBUS_WDATA,
  output logic [3:0]        oBUS_BE,
  input  logic              iBUS_READY,
  input  logic [DATA_W-1:0] iBUS_RDATA,
  input  logic              iBUS_ERR
);

  memState_t         r_state;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic              w_misaligned;
  logic              w_timeout;

  assign w_misaligned = isMisaligned(iBE);

`ifdef BUS_TIMEOUT_EN
  logic w_wdogClr;
  logic w_wdogEn;

  assign w_wdogClr = (r_state == IDLE) && iMEM && !w_misaligned;
  assign w_wdogEn  = (r_state == REQ) && !iBUS_READY;

  bus_wdog_rv32 #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (TIMEOUT_W)
  ) uWdog (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClr     (w_wdogClr),
    .iEn      (w_wdogEn),
    .oExpired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iMEM) begin
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= RESP;
            end else begin
              r_valid <= 1'b1;
              r_we    <= ~iRW;
              r_addr  <= {iADDR[ADDR_W-1:2], 2'b00};
              r_wdata <= iWDATA;
              r_be    <= iBE;
              r_err   <= 1'b0;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          // A handshake in the expiry cycle takes priority over the abort.
          if (iBUS_READY) begin
            r_rdata <= r_we ? '0 : iBUS_RDATA;
            r_err   <= iBUS_ERR;
            r_valid <= 1'b0;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oStallD    = ((r_state == IDLE) && iMEM) || (r_state == REQ);
  assign oRDATA     = r_rdata;
  assign oERR       = r_err;
  assign oBUS_VALID = r_valid;
  assign oBUS_WE    = r_we;
  assign oBUS_ADDR  = r_addr;
  assign oBUS_WDATA = r_wdata;
  assign oBUS_BE    = r_be;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge_rv32.sv
// ============================================================================
// Module  : tb_dmem_bridge_rv32
// Brief   : Randomized self-checking bench for dmem_bridge_rv32 with a
//           transaction-level model and per-cycle output comparison.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bridge_rv32;

  localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iMEM, iRW, iBUS_READY, iBUS_ERR;
  logic [31:0] iADDR, iWDATA, iBUS_RDATA;
  logic [3:0]  iBE;
  logic [31:0] oRDATA, oBUS_ADDR, oBUS_WDATA;
  logic        oStallD, oERR, oBUS_VALID, oBUS_WE;
  logic [3:0]  oBUS_BE;

  always #5 iCLK = ~iCLK;

  dmem_bridge_rv32 #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW), .iADDR(iADDR),
    .iWDATA(iWDATA), .iBE(iBE), .oRDATA(oRDATA), .oStallD(oStallD),
    .oERR(oERR), .oBUS_VALID(oBUS_VALID), .oBUS_WE(oBUS_WE),
    .oBUS_ADDR(oBUS_ADDR), .oBUS_WDATA(oBUS_WDATA), .oBUS_BE(oBUS_BE),
    .iBUS_READY(iBUS_READY), .iBUS_RDATA(iBUS_RDATA), .iBUS_ERR(iBUS_ERR)
  );

  int checks = 0;
  int failures = 0;

  // Model: values the bridge must present this cycle, and values it holds.
  bit          chkEn = 1'b0;
  logic        eStall, eValid, eWe, eErr;
  logic [31:0] eAddr, eWdata, eRdata;
  logic [3:0]  eBe;
  logic        hWe, hErr;
  logic [31:0] hAddr, hWdata, hRdata;
  logic [3:0]  hBe;

  int          stallCnt, validCnt;
  logic [31:0] lastRdata;
  logic        lastErr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (chkEn) begin
      chk("stall", {31'd0, oStallD}, {31'd0, eStall});
      chk("valid", {31'd0, oBUS_VALID}, {31'd0, eValid});
      chk("we", {31'd0, oBUS_WE}, {31'd0, eWe});
      chk("addr", oBUS_ADDR, eAddr);
      chk("wdata", oBUS_WDATA, eWdata);
      chk("be", {28'd0, oBUS_BE}, {28'd0, eBe});
      chk("rdata", oRDATA, eRdata);
      chk("err", {31'd0, oERR}, {31'd0, eErr});
    end
  end

  task automatic setExp(input logic stall, input logic valid);
    eStall = stall; eValid = valid;
    eWe = hWe; eAddr = hAddr; eWdata = hWdata; eBe = hBe;
    eRdata = hRdata; eErr = hErr;
  endtask

  task automatic garbage();
    iRW = 1'($urandom); iADDR = $urandom; iWDATA = $urandom; iBE = 4'($urandom);
    iBUS_RDATA = $urandom; iBUS_ERR = 1'($urandom);
  endtask

  task automatic step();
    @(negedge iCLK);
    if (oStallD) stallCnt++;
    if (oBUS_VALID) validCnt++;
    lastRdata = oRDATA;
    lastErr = oERR;
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    garbage(); iMEM = 1'b0; iBUS_READY = 1'($urandom);
    setExp(1'b0, 1'b0);
    step();
  endtask

  task automatic txn(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int waits, input logic [31:0] rdata,
                     input bit berr);
    bit legal;
    bit done;
    int k;
    legal = ($countones(be) == 1) || be == 4'h3 || be == 4'hC || be == 4'hF;
    stallCnt = 0; validCnt = 0;
    garbage();
    iMEM = 1'b1; iRW = rw; iADDR = addr; iWDATA = wdata; iBE = be;
    iBUS_READY = 1'($urandom);
    setExp(1'b1, 1'b0);
    step();
    if (!legal) begin
      hRdata = 32'd0; hErr = 1'b1;
    end else begin
      hWe = !rw; hAddr = addr & 32'hFFFF_FFFC; hWdata = wdata; hBe = be; hErr = 1'b0;
      done = 1'b0; k = 0;
      while (!done) begin
        garbage(); iMEM = 1'($urandom);
        iBUS_READY = (k == waits);
        if (k == waits) begin iBUS_RDATA = rdata; iBUS_ERR = berr; end
        setExp(1'b1, 1'b1);
        step();
        if (k == waits) begin
          hRdata = rw ? rdata : 32'd0; hErr = berr; done = 1'b1;
        end else if (TMO_EN && k == TO - 1) begin
          hRdata = 32'd0; hErr = 1'b1; done = 1'b1;
        end
        k++;
      end
    end
    garbage(); iMEM = 1'($urandom); iBUS_READY = 1'($urandom);
    setExp(1'b0, 1'b0);
    step();
  endtask

  task automatic clearModel();
    hWe = 1'b0; hErr = 1'b0; hAddr = '0; hWdata = '0; hRdata = '0; hBe = '0;
  endtask

  initial begin
    logic [3:0] legalBe [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [3:0] be;
    iRST = 1'b0; iMEM = 1'b0; iBUS_READY = 1'b0;
    garbage();
    clearModel();
    #12;
    chk("rst_valid", {31'd0, oBUS_VALID}, 32'd0);
    chk("rst_rdata", oRDATA, 32'd0);
    chk("rst_stall", {31'd0, oStallD}, 32'd0);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    chkEn = 1'b1;
    idle();

    txn(1'b1, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
    chk("rd0_stall_cycles", stallCnt, 32'd2);
    chk("rd0_rdata", lastRdata, 32'hDEADBEEF);
    chk("rd0_err", {31'd0, lastErr}, 32'd0);
    chk("rd0_addr", oBUS_ADDR, 32'h100);

    txn(1'b0, 32'h204, 32'h12345678, 4'b1100, 3, 32'hCAFEF00D, 1'b0);
    chk("wr3_valid_cycles", validCnt, 32'd4);
    chk("wr3_stall_cycles", stallCnt, 32'd5);
    chk("wr3_rdata", lastRdata, 32'd0);

    txn(1'b1, 32'h102, 32'h0, 4'b0110, 0, 32'h0, 1'b0);
    chk("mis_valid_cycles", validCnt, 32'd0);
    chk("mis_err", {31'd0, lastErr}, 32'd1);
    chk("mis_rdata", lastRdata, 32'd0);

    txn(1'b1, 32'h300, 32'h0, 4'hF, 1, 32'h55AA55AA, 1'b1);
    chk("berr_err", {31'd0, lastErr}, 32'd1);
    txn(1'b0, 32'h304, 32'hA5A5A5A5, 4'h1, 0, 32'h0, 1'b0);
    chk("berr_cleared", {31'd0, lastErr}, 32'd0);

`ifdef BUS_TIMEOUT_EN
    txn(1'b1, 32'h400, 32'h0, 4'hF, 20, 32'h11111111, 1'b0);
    chk("tmo_valid_cycles", validCnt, 32'd4);
    chk("tmo_err", {31'd0, lastErr}, 32'd1);
    chk("tmo_rdata", lastRdata, 32'd0);
`endif

    // Reset two cycles into a request: outputs must clear without a clock edge.
    garbage(); iMEM = 1'b1; iRW = 1'b1; iADDR = 32'h500; iBE = 4'hF; iBUS_READY = 1'b0;
    setExp(1'b1, 1'b0);
    step();
    hWe = 1'b0; hAddr = 32'h500; hWdata = iWDATA; hBe = 4'hF; hErr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      garbage(); iMEM = 1'b0; iBUS_READY = 1'b0;
      setExp(1'b1, 1'b1);
      step();
    end
    chkEn = 1'b0;
    iMEM = 1'b0;
    #2 iRST = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, oBUS_VALID}, 32'd0);
    chk("mrst_addr", oBUS_ADDR, 32'd0);
    chk("mrst_be", {28'd0, oBUS_BE}, 32'd0);
    chk("mrst_stall", {31'd0, oStallD}, 32'd0);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    clearModel();
    chkEn = 1'b1;
    txn(1'b1, 32'h600, 32'h0, 4'h3, 2, 32'h0BADF00D, 1'b0);
    chk("post_rst_rdata", lastRdata, 32'h0BADF00D);

    for (int n = 0; n < 150; n++) begin
      be = ($urandom_range(0, 1) == 0) ? legalBe[$urandom_range(0, 6)] : 4'($urandom);
      txn(1'($urandom), $urandom, $urandom, be, $urandom_range(0, 6), $urandom,
          ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle();
    end

    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
